// File: rtl/bus_master.sv
// bus_master: single-outstanding initiator for the shared CS / RD_WR / data
// register bus. One command is accepted at a time, CS is held for
// WAIT_CYCLES+1 clocks, then one response cycle doubles as the bus turnaround.
`timescale 1ns/1ps

module bus_master #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  CS,
    output logic                  RD_WR,
    inout  wire  [DATA_WIDTH-1:0] data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // Last ACCESS cycle index; the counter is 4 bits wide.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t                  state_reg,     state_next;
    logic [3:0]              cnt_reg,       cnt_next;
    logic [ADDR_WIDTH-1:0]   addr_reg,      addr_next;
    logic                    rd_wr_reg,     rd_wr_next;
    logic                    cs_reg,        cs_next;
    logic                    oe_reg,        oe_next;
    logic [DATA_WIDTH-1:0]   wdata_reg,     wdata_next;
    logic                    rsp_valid_reg, rsp_valid_next;
    logic [DATA_WIDTH-1:0]   rdata_reg,     rdata_next;
    logic                    ready_reg,     ready_next;
    logic                    busy_reg,      busy_next;

    // State and every output are registered; reset forces the idle bus at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            rd_wr_reg     <= 1'b0;
            cs_reg        <= 1'b0;
            oe_reg        <= 1'b0;
            wdata_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rdata_reg     <= '0;
            ready_reg     <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            rd_wr_reg     <= rd_wr_next;
            cs_reg        <= cs_next;
            oe_reg        <= oe_next;
            wdata_reg     <= wdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rdata_reg     <= rdata_next;
            ready_reg     <= ready_next;
            busy_reg      <= busy_next;
        end
    end

    // Next-state: accept in IDLE, hold CS for the wait count, one response cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (cmd_valid) state_next = ST_ACCESS;
            ST_ACCESS: if (cnt_reg == WAIT_LAST) state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output next-values: bus signals change only on accept and at the CS-fall edge.
    always_comb begin
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        rd_wr_next     = rd_wr_reg;
        cs_next        = cs_reg;
        oe_next        = oe_reg;
        wdata_next     = wdata_reg;
        rsp_valid_next = rsp_valid_reg;
        rdata_next     = rdata_reg;
        ready_next     = ready_reg;
        busy_next      = busy_reg;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_next  = cmd_addr;
                    rd_wr_next = cmd_rd_wr;
                    wdata_next = cmd_wdata;
                    cs_next    = 1'b1;
                    // Only writes ever enable the data driver.
                    oe_next    = !cmd_rd_wr;
                    ready_next = 1'b0;
                    busy_next  = 1'b1;
                    cnt_next   = '0;
                end
            end
            ST_ACCESS: begin
                if (cnt_reg == WAIT_LAST) begin
                    // Release the bus on the same edge the read data is captured.
                    cs_next        = 1'b0;
                    oe_next        = 1'b0;
                    rsp_valid_next = 1'b1;
                    if (rd_wr_reg) rdata_next = data;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_RESP: begin
                rsp_valid_next = 1'b0;
                busy_next      = 1'b0;
                ready_next     = 1'b1;
            end
            default: begin
                cs_next        = 1'b0;
                oe_next        = 1'b0;
                rsp_valid_next = 1'b0;
                busy_next      = 1'b0;
                ready_next     = 1'b1;
            end
        endcase
    end

    assign data      = oe_reg ? wdata_reg : {DATA_WIDTH{1'bz}};
    assign cmd_ready = ready_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rdata_reg;
    assign busy      = busy_reg;
    assign address   = addr_reg;
    assign CS        = cs_reg;
    assign RD_WR     = rd_wr_reg;

endmodule
